// File: rtl/pulse_req_initiator_pkg.sv
// Shared types and defaults for the pulse request initiator.
// State encoding plus parameter defaults and a counter-width helper.
package pulse_req_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_ACK,
      GAP
   } state_e;

   localparam int CNT_W_DEF     = 4;
   localparam int TIMEOUT_DEF   = 8;
   localparam int MAX_RETRY_DEF = 3;
   localparam int GAP_DEF       = 2;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_bits(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pulse_req_initiator_if.sv
// Trigger/acknowledge/status bundle of the pulse request initiator.
// master = initiator side, slave = event source plus responder side.
interface pulse_req_initiator_if
   import pulse_req_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);

   logic             trig;
   logic             active;
   logic             err_clr;
   logic             a;
   logic [CNT_W-1:0] pending;
   logic             busy;
   logic             err;
   logic             drop;

   modport master (
      input  trig,
      input  active,
      input  err_clr,
      output a,
      output pending,
      output busy,
      output err,
      output drop
   );

   modport slave (
      output trig,
      output active,
      output err_clr,
      input  a,
      input  pending,
      input  busy,
      input  err,
      input  drop
   );

endinterface

// File: rtl/pulse_req_initiator_sat_updown_counter.sv
// Saturating up/down counter used as the pending-event queue.
// Simultaneous inc and dec cancel; inc at full is rejected.
module sat_updown_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         full,
   output logic         rejected
);

   localparam logic [W-1:0] MAX_V = '1;

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign full  = (count_q == MAX_V);
   assign count = count_q;

   // Next count and rejection flag from the inc/dec pair.
   always_comb begin
      count_d  = count_q;
      rejected = 1'b0;
      if (inc && !dec) begin
         if (full) begin
            rejected = 1'b1;
         end else begin
            count_d = count_q + W'(1);
         end
      end else if (dec && !inc && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pulse_req_initiator.sv
// Initiator of the single-wire request/active pulse protocol.
// Queues triggers, pulses a, waits for active, retries, then drops.
module pulse_req_initiator
   import pulse_req_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF,
   parameter int MAX_RETRY = MAX_RETRY_DEF,
   parameter int GAP       = GAP_DEF
) (
   input logic                  clk,
   input logic                  reset,
   pulse_req_initiator_if.master bus
);

   localparam int WAIT_W  = cnt_bits(TIMEOUT);
   localparam int RETRY_W = cnt_bits(MAX_RETRY);
   localparam int GAP_W   = cnt_bits(GAP);

   localparam logic [WAIT_W-1:0]  TO_V  = WAIT_W'(TIMEOUT);
   localparam logic [RETRY_W-1:0] MR_V  = RETRY_W'(MAX_RETRY);
   localparam logic [GAP_W-1:0]   GAP_V = GAP_W'(GAP);

   // The GAP parameter shadows the state literal of the same name.
   localparam state_e ST_GAP = pulse_req_pkg::GAP;

   state_e              state_q;
   state_e              state_d;
   logic [WAIT_W-1:0]   wait_q;
   logic [WAIT_W-1:0]   wait_d;
   logic [RETRY_W-1:0]  retry_q;
   logic [RETRY_W-1:0]  retry_d;
   logic [GAP_W-1:0]    gap_q;
   logic [GAP_W-1:0]    gap_d;
   logic                err_q;
   logic                err_d;

   logic                dec;
   logic                err_set;
   logic                pend_nz;
   logic                full;
   logic                rejected;
   logic [CNT_W-1:0]    count;

   sat_updown_counter #(
      .W (CNT_W)
   ) u_pending (
      .clk      (clk),
      .reset    (reset),
      .inc      (bus.trig),
      .dec      (dec),
      .count    (count),
      .full     (full),
      .rejected (rejected)
   );

   assign pend_nz = full || (count != '0);

   assign bus.a       = (state_q == REQ);
   assign bus.busy    = (state_q != IDLE);
   assign bus.pending = count;
   assign bus.err     = err_q;
   assign bus.drop    = rejected;

   // Next state, wait/gap/retry counters and queue decrement.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      retry_d = retry_q;
      gap_d   = gap_q;
      dec     = 1'b0;
      err_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pend_nz || bus.trig) begin
               state_d = REQ;
            end
         end
         REQ: begin
            state_d = WAIT_ACK;
            wait_d  = WAIT_W'(1);
         end
         WAIT_ACK: begin
            if (bus.active) begin
               dec     = 1'b1;
               retry_d = '0;
               state_d = ST_GAP;
               gap_d   = GAP_W'(1);
            end else if (wait_q == TO_V) begin
               if (retry_q < MR_V) begin
                  retry_d = retry_q + RETRY_W'(1);
               end else begin
                  err_set = 1'b1;
                  dec     = 1'b1;
                  retry_d = '0;
               end
               state_d = ST_GAP;
               gap_d   = GAP_W'(1);
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_V) begin
               // No decrement happens in GAP, so a trig now
               // is enough to make the next pending non-zero.
               if (pend_nz || bus.trig || (retry_q != '0)) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sticky error: a new drop outranks a same-cycle clear.
   always_comb begin
      err_d = err_set | (err_q & ~bus.err_clr);
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wait_q  <= '0;
         retry_q <= '0;
         gap_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         retry_q <= retry_d;
         gap_q   <= gap_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_pulse_req_initiator.sv
// Scoreboard bench for pulse_req_initiator.
// Timeline reference model feeds a queue popped by a monitor.
module tb_pulse_req_initiator;

   localparam int CW   = 4;
   localparam int TO   = 8;
   localparam int MR   = 3;
   localparam int GP   = 2;
   localparam int MAXP = 15;

   typedef struct {
      int cyc;
      int a;
      int busy;
      int pend;
      int err;
      int drop;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   pulse_req_initiator_if #(.CNT_W(CW)) bus();

   pulse_req_initiator #(
      .CNT_W     (CW),
      .TIMEOUT   (TO),
      .MAX_RETRY (MR),
      .GAP       (GP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t sbq[$];
   int   a_log[$];
   int   drop_cnt = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 0;
   bit   a_prev = 0;
   exp_t me;

   // model: timeline of request cycles, ack windows and gap ends
   int mc, m_idle, m_r, m_win, m_gend, m_pend, m_ret, m_err;

   function automatic void chk(string nm, logic [31:0] act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t",
                  nm, act, exp, $time);
      end
   endfunction

   task automatic m_reset();
      mc = 0; m_idle = 1; m_r = -100; m_win = 0;
      m_gend = -100; m_pend = 0; m_ret = 0; m_err = 0;
   endtask

   task automatic cyc(input bit tg, input bit ac, input bit clr);
      exp_t e;
      int   dec, set, pn, drp;
      @(posedge clk);
      #1;
      bus.trig = tg;
      bus.active = ac;
      bus.err_clr = clr;
      a_prev = bus.a;
      dec = 0;
      set = 0;
      if (!m_idle && m_win && mc > m_r) begin
         if (ac) begin
            dec = 1; m_ret = 0; m_win = 0; m_gend = mc + GP;
         end else if (mc == m_r + TO) begin
            if (m_ret < MR) m_ret++;
            else begin set = 1; dec = 1; m_ret = 0; end
            m_win = 0;
            m_gend = mc + GP;
         end
      end
      drp = (tg && !dec && m_pend == MAXP) ? 1 : 0;
      e.cyc = mc;
      e.a = (!m_idle && mc == m_r) ? 1 : 0;
      e.busy = m_idle ? 0 : 1;
      e.pend = m_pend;
      e.err = m_err;
      e.drop = drp;
      sbq.push_back(e);
      pn = m_pend;
      if (tg && !dec && m_pend < MAXP) pn++;
      else if (dec && !tg && m_pend > 0) pn--;
      if (!m_idle && !m_win && mc == m_gend) begin
         if (pn > 0 || m_ret > 0) begin m_r = mc + 1; m_win = 1; end
         else m_idle = 1;
      end else if (m_idle && (m_pend > 0 || tg)) begin
         m_idle = 0; m_r = mc + 1; m_win = 1;
      end
      m_pend = pn;
      if (set) m_err = 1;
      else if (clr) m_err = 0;
      mc++;
   endtask

   always @(negedge clk) begin
      if (mon_en && sbq.size() > 0) begin
         me = sbq.pop_front();
         if (bus.a === 1'b1) a_log.push_back(me.cyc);
         if (bus.drop === 1'b1) drop_cnt++;
         chk("sb_a", bus.a, me.a);
         chk("sb_busy", bus.busy, me.busy);
         chk("sb_pending", bus.pending, me.pend);
         chk("sb_err", bus.err, me.err);
         chk("sb_drop", bus.drop, me.drop);
      end
   end

   initial begin
      int c0, got;
      bus.trig = 0; bus.active = 0; bus.err_clr = 0;
      reset = 1'b1;
      m_reset();
      #3;
      chk("rst_a", bus.a, 0);
      chk("rst_pending", bus.pending, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_drop", bus.drop, 0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      mon_en = 1;

      // single event, responder acks one cycle after a
      a_log.delete();
      c0 = mc;
      cyc(1, 0, 0);
      cyc(0, a_prev, 0);
      chk("t1_pend_c1", bus.pending, 1);
      chk("t1_a_c1", bus.a, 1);
      for (int i = 2; i < 10; i++) begin
         cyc(0, a_prev, 0);
         if (i == 3) chk("t1_pend_c3", bus.pending, 0);
         if (i == 4) chk("t1_busy_c4", bus.busy, 1);
         if (i == 5) chk("t1_busy_c5", bus.busy, 0);
      end
      chk("t1_a_count", a_log.size(), 1);
      if (a_log.size() > 0) chk("t1_a_cycle", a_log[0] - c0, 1);
      chk("t1_err", bus.err, 0);

      // no responder: 4 attempts 11 cycles apart, then err
      a_log.delete();
      c0 = mc;
      cyc(1, 0, 0);
      repeat (50) cyc(0, 0, 0);
      chk("t2_a_count", a_log.size(), 4);
      if (a_log.size() == 4) begin
         chk("t2_first_a", a_log[0] - c0, 1);
         for (int i = 1; i < 4; i++)
            chk("t2_spacing", a_log[i] - a_log[i-1], 11);
      end
      chk("t2_err", bus.err, 1);
      chk("t2_pending", bus.pending, 0);
      chk("t2_busy", bus.busy, 0);

      // err_clr during the final timeout: set wins, then clear
      cyc(1, 0, 0);
      for (int i = 1; i < 48; i++) begin
         cyc(0, 0, (i == 42) || (i == 43));
         if (i == 43) chk("t3_set_wins", bus.err, 1);
         if (i == 44) chk("t3_clr", bus.err, 0);
      end

      // burst of 20 triggers, responder silent
      drop_cnt = 0;
      for (int i = 0; i < 20; i++) cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("t4_pending_sat", bus.pending, 15);
      chk("t4_drop_count", drop_cnt, 5);

      // trig on the ack cycle at full: no drop, count holds
      got = 0;
      for (int i = 0; i < 40 && got == 0; i++) begin
         if (a_prev) begin
            cyc(1, 1, 0);
            got = 1;
         end else begin
            cyc(0, 0, 0);
         end
      end
      chk("t5_ack_seen", got, 1);
      cyc(0, 0, 0);
      chk("t5_pending_hold", bus.pending, 15);
      chk("t5_no_drop", drop_cnt, 5);
      repeat (100) cyc(0, a_prev, 0);
      chk("t5_drained", bus.pending, 0);

      // async reset mid-WAIT_ACK with three queued
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("t6_pend_pre", bus.pending, 3);
      chk("t6_busy_pre", bus.busy, 1);
      @(negedge clk);
      #1;
      mon_en = 0;
      reset = 1'b1;
      #1;
      chk("t6_rst_a", bus.a, 0);
      chk("t6_rst_pending", bus.pending, 0);
      chk("t6_rst_busy", bus.busy, 0);
      chk("t6_rst_err", bus.err, 0);
      chk("t6_rst_drop", bus.drop, 0);
      sbq.delete();
      m_reset();
      a_prev = 0;
      bus.trig = 0; bus.active = 0; bus.err_clr = 0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      mon_en = 1;
      a_log.delete();
      repeat (10) cyc(0, 0, 0);
      chk("t6_no_a", a_log.size(), 0);

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         bit tg, ac, cl;
         if ((i / 150) % 2 == 1) tg = ($urandom % 2) == 0;
         else tg = ($urandom % 8) == 0;
         if (a_prev) ac = ($urandom % 4) != 0;
         else ac = ($urandom % 6) == 0;
         cl = ($urandom % 16) == 0;
         cyc(tg, ac, cl);
      end
      repeat (3) cyc(0, 0, 0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
